// File: rtl/nf1_arb_pkg.sv
// Shared types for the per-port packet arbiter and the tuser field layout
// used by the output-queue blocks.
package nf1_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } arb_state_e;

  localparam int TUSER_LEN_LO = 0;
  localparam int TUSER_LEN_HI = 15;
  localparam int TUSER_SRC_LO = 16;
  localparam int TUSER_SRC_HI = 23;
  localparam int TUSER_DST_LO = 24;
  localparam int TUSER_DST_HI = 31;

endpackage

// File: rtl/nf1_axis_reg_slice.sv
// Two-entry AXIS skid slice: registered output plus one skid register, so
// upstream ready depends only on local state.
module nf1_axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
);

  logic [W-1:0] r_out, r_skid;
  logic         r_out_vld, r_skid_vld;
  logic         w_push;

  assign o_ready = !r_skid_vld;
  assign w_push  = i_valid && !r_skid_vld;
  assign o_data  = r_out;
  assign o_valid = r_out_vld;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out      <= '0;
      r_skid     <= '0;
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (!r_out_vld || i_ready) begin
      // Output slot is free this cycle: refill from skid first to keep order.
      if (r_skid_vld) begin
        r_out      <= r_skid;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else if (w_push) begin
        r_out     <= i_data;
        r_out_vld <= 1'b1;
      end else begin
        r_out_vld <= 1'b0;
      end
    end else if (w_push) begin
      r_skid     <= i_data;
      r_skid_vld <= 1'b1;
    end
  end

endmodule

// File: rtl/nf1_port_rr_arbiter.sv
// Packet-granular round-robin merge of NUM_IN AXIS sources into one MAC
// transmit stream; a grant is held from first beat to tlast.
module nf1_port_rr_arbiter
  import nf1_arb_pkg::*;
#(
  parameter int NUM_IN             = 4,
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int GRANT_W            = $clog2(NUM_IN)
) (
  input  logic                                  axi_aclk,
  input  logic                                  axi_resetn,
  input  logic [NUM_IN*C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_IN*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [NUM_IN*C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic [NUM_IN-1:0]                     s_axis_tvalid,
  input  logic [NUM_IN-1:0]                     s_axis_tlast,
  output logic [NUM_IN-1:0]                     s_axis_tready,
  output logic [C_AXIS_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]        m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]         m_axis_tuser,
  output logic                                  m_axis_tvalid,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready,
  output logic [GRANT_W-1:0]                    arb_grant,
  output logic                                  arb_busy
);

  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;
  localparam int PW = DW + SW + UW + 1;

  arb_state_e         r_state, w_state_nxt;
  logic [GRANT_W-1:0] r_grant, r_rr_ptr, w_pick, w_idx;
  logic               w_found, w_s_ready, w_push_vld, w_acc, w_acc_last;
  logic [PW-1:0]      w_push_data, w_m_data;

  // Scan from the round-robin pointer, wrapping modulo NUM_IN.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    w_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_idx = (int'(r_rr_ptr) + i >= NUM_IN) ? GRANT_W'(int'(r_rr_ptr) + i - NUM_IN)
                                             : GRANT_W'(int'(r_rr_ptr) + i);
      if (!w_found && s_axis_tvalid[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_push_vld  = (r_state == PKT) && s_axis_tvalid[r_grant];
  assign w_acc       = w_push_vld && w_s_ready;
  assign w_acc_last  = w_acc && s_axis_tlast[r_grant];
  assign w_push_data = {s_axis_tlast[r_grant],
                        s_axis_tuser[r_grant*UW +: UW],
                        s_axis_tstrb[r_grant*SW +: SW],
                        s_axis_tdata[r_grant*DW +: DW]};

  always_comb begin
    s_axis_tready = '0;
    if (r_state == PKT) s_axis_tready[r_grant] = w_s_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = PKT;
      PKT:     if (w_acc_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_found) r_grant <= w_pick;
      if (w_acc_last)
        r_rr_ptr <= (r_grant == GRANT_W'(NUM_IN - 1)) ? '0 : r_grant + 1'b1;
    end
  end

  nf1_axis_reg_slice #(.W(PW)) u_slice (
    .i_clk   (axi_aclk),
    .i_rst_n (axi_resetn),
    .i_data  (w_push_data),
    .i_valid (w_push_vld),
    .o_ready (w_s_ready),
    .o_data  (w_m_data),
    .o_valid (m_axis_tvalid),
    .i_ready (m_axis_tready)
  );

  assign {m_axis_tlast, m_axis_tuser, m_axis_tstrb, m_axis_tdata} = w_m_data;
  assign arb_grant = r_grant;
  assign arb_busy  = (r_state == PKT);

endmodule

// File: tb/tb_nf1_port_rr_arbiter.sv
// Directed bench: per-input source queues feed the DUT; expected beats go
// into a scoreboard queue that a monitor checks on every output transfer.
module tb_nf1_port_rr_arbiter;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
    logic [7:0]   gap;
  } beat_t;

  logic          clk = 0, rstn = 0;
  logic [1023:0] s_tdata = '0;
  logic [127:0]  s_tstrb = '0;
  logic [511:0]  s_tuser = '0;
  logic [3:0]    s_tvalid = '0, s_tlast = '0, s_tready;
  logic [255:0]  m_tdata;
  logic [31:0]   m_tstrb;
  logic [127:0]  m_tuser;
  logic          m_tvalid, m_tlast, m_tready = 1'b1;
  logic [1:0]    arb_grant;
  logic          arb_busy;

  beat_t src_q[4][$];
  beat_t exp_q[$];
  int    wt[4];
  logic [3:0] acc = '0;
  int    total = 0, bad = 0, n_xfer = 0, cyc = 0;
  int    xfer_cyc[$];

  nf1_port_rr_arbiter dut (
    .axi_aclk(clk), .axi_resetn(rstn),
    .s_axis_tdata(s_tdata), .s_axis_tstrb(s_tstrb), .s_axis_tuser(s_tuser),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tstrb(m_tstrb), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .arb_grant(arb_grant), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] mkd(input int s, input int k);
    return {32'(s), 192'h0, 32'(k)};
  endfunction

  task automatic add_beat(input int s, input logic [255:0] d, input logic [31:0] st,
                          input logic [127:0] u, input logic l, input int g);
    beat_t b;
    b.data = d; b.strb = st; b.user = u; b.last = l; b.gap = 8'(g);
    src_q[s].push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic add_pkt(input int s, input int n, input int gap_at, input int gap);
    for (int k = 0; k < n; k++)
      add_beat(s, mkd(s, k), '1, 128'(s * 100 + k), k == n - 1, (k == gap_at) ? gap : 0);
  endtask

  task automatic wait_xfers(input string nm, input int n);
    int t = 0;
    while (n_xfer < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 256'(n_xfer), 256'(n));
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      wt[i] = 0;
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  // Source driver: handshake sampled at negedge, next beat presented after posedge.
  initial forever begin
    @(negedge clk);
    acc = s_tvalid & s_tready;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        wt[i] = 0;
      end
      if (src_q[i].size() > 0 && wt[i] < int'(src_q[i][0].gap)) begin
        s_tvalid[i] = 1'b0;
        wt[i]++;
      end else if (src_q[i].size() > 0) begin
        s_tvalid[i]             = 1'b1;
        s_tdata[i*256 +: 256]   = src_q[i][0].data;
        s_tstrb[i*32 +: 32]     = src_q[i][0].strb;
        s_tuser[i*128 +: 128]   = src_q[i][0].user;
        s_tlast[i]              = src_q[i][0].last;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rstn && m_tvalid && m_tready) begin
      n_xfer++;
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_tdata, 256'h0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_tdata, e.data);
        chk("beat_strb", 256'(m_tstrb), 256'(e.strb));
        chk("beat_user", 256'(m_tuser), 256'(e.user));
        chk("beat_last", 256'(m_tlast), 256'(e.last));
      end
    end
  end

  initial begin
    int b, t, viol;
    logic [255:0] held;
    clear_all();
    @(negedge clk);
    chk("rst_tready", 256'(s_tready), 256'h0);
    chk("rst_mvalid", 256'(m_tvalid), 256'h0);
    chk("rst_mlast", 256'(m_tlast), 256'h0);
    chk("rst_mdata", m_tdata, 256'h0);
    chk("rst_grant", 256'(arb_grant), 256'h0);
    chk("rst_busy", 256'(arb_busy), 256'h0);
    @(negedge clk);
    rstn = 1;

    // 1: inputs 0 and 2 with 3-beat packets; last beat of input 2 carries special tuser/tstrb.
    @(negedge clk);
    b = n_xfer;
    add_pkt(0, 3, -1, 0);
    add_beat(2, mkd(2, 0), '1, 128'h11, 1'b0, 0);
    add_beat(2, mkd(2, 1), '1, 128'h12, 1'b0, 0);
    add_beat(2, mkd(2, 2), 32'h0000_00FF, 128'hDEAD_BEEF, 1'b1, 0);
    @(negedge clk);
    chk("t1_c0_busy", 256'(arb_busy), 256'h0);
    chk("t1_c0_mvalid", 256'(m_tvalid), 256'h0);
    @(negedge clk);
    chk("t1_c1_busy", 256'(arb_busy), 256'h1);
    chk("t1_c1_grant", 256'(arb_grant), 256'h0);
    chk("t1_c1_tready", 256'(s_tready), 256'h1);
    chk("t1_c1_mvalid", 256'(m_tvalid), 256'h0);
    @(negedge clk);
    chk("t1_c2_mvalid", 256'(m_tvalid), 256'h1);
    wait_xfers("t1_count", b + 6);
    chk("t1_span", 256'(xfer_cyc[b+5] - xfer_cyc[b]), 256'd6);
    chk("t1_grant2", 256'(arb_grant), 256'd2);
    // rr_ptr is now 3: input 3 must beat input 0.
    b = n_xfer;
    add_pkt(3, 1, -1, 0);
    add_pkt(0, 1, -1, 0);
    wait_xfers("t1_ptr3_count", b + 2);

    // 2: all four inputs valid with 1-beat packets, order 0,1,2,3,0.
    do_reset();
    b = n_xfer;
    add_pkt(0, 1, -1, 0);
    add_pkt(1, 1, -1, 0);
    add_pkt(2, 1, -1, 0);
    add_pkt(3, 1, -1, 0);
    add_pkt(0, 1, -1, 0);
    wait_xfers("t2_count", b + 5);
    chk("t2_span", 256'(xfer_cyc[b+4] - xfer_cyc[b]), 256'd8);

    // 3: backpressure for 5 cycles inside a 16-beat packet.
    @(negedge clk);
    b = n_xfer;
    add_pkt(1, 16, -1, 0);
    wait_xfers("t3_pre", b + 5);
    @(posedge clk);
    #1 m_tready = 1'b0;
    @(negedge clk);
    held = m_tdata;
    viol = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_tdata !== held || m_tvalid !== 1'b1) viol++;
    end
    chk("t3_stable", 256'(viol), 256'h0);
    chk("t3_tready_low", 256'(s_tready), 256'h0);
    @(posedge clk);
    #1 m_tready = 1'b1;
    wait_xfers("t3_count", b + 16);

    // 4: granted input 1 stalls 4 cycles mid-packet while input 3 waits.
    @(negedge clk);
    b = n_xfer;
    add_pkt(1, 6, 2, 4);
    t = 0;
    while (!(arb_busy && arb_grant == 2'd1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t4_grant1", 256'({arb_busy, arb_grant}), 256'h5);
    add_pkt(3, 1, -1, 0);
    viol = 0;
    t = 0;
    while (src_q[1].size() > 0 && t < 50) begin
      if (!arb_busy || arb_grant != 2'd1 || s_tready[3]) viol++;
      @(negedge clk);
      t++;
    end
    chk("t4_hold", 256'(viol), 256'h0);
    wait_xfers("t4_count", b + 7);

    // 5: async reset mid-packet, then arbitration restarts at input 0.
    @(negedge clk);
    b = n_xfer;
    add_pkt(0, 1, -1, 0);
    wait_xfers("t5_pre0", b + 1);
    add_pkt(2, 8, -1, 0);
    wait_xfers("t5_pre2", b + 3);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t5_rst_mvalid", 256'(m_tvalid), 256'h0);
    chk("t5_rst_tready", 256'(s_tready), 256'h0);
    chk("t5_rst_busy", 256'(arb_busy), 256'h0);
    clear_all();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("t5_rst_grant", 256'(arb_grant), 256'h0);
    b = n_xfer;
    add_pkt(0, 1, -1, 0);
    add_pkt(1, 1, -1, 0);
    wait_xfers("t5_count", b + 2);

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drained", 256'(exp_q.size()), 256'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
